// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, branch flush and divider occupancy controller
//
// Purpose:
//   Resolves load-use hazards, taken branch/jump redirects and multi-cycle
//   divide occupancy for the IF/ID/EX core. Drives the front-end stall, the
//   IR flush, the decoder flush (EX bubble) and the divider start handshake.
//   Keeps a watchdog on the divider and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   id_rs1, id_rs2  source register fields of the instruction in ID
//   ex_dst          destination register of the EX-stage instruction
//   ex_write_reg    EX-stage instruction writes a register
//   ex_info_load    EX-stage load kind (NOTLOAD when not a load)
//   ex_alucode      EX-stage ALU operation code
//   br_taken        EX-stage redirect (taken branch, JAL, JALR)
//   div_done        divider writeback pulse
//   stall           hold PC and IR                       (combinational)
//   flush_f         replace IR with a NOP                  (combinational)
//   flush_d         bubble into EX (decoder flush)         (combinational)
//   div_start       divider start pulse                    (combinational)
//   div_busy        divider occupied                       (registered)
//   div_err         sticky divider watchdog flag           (registered)
//   stall_cycles    saturating count of stalled cycles     (registered)

module hazard_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 40,
    // Encodings shared with the decoder.
    parameter logic [2:0]  NOTLOAD     = 3'd0,
    parameter logic [4:0]  ALU_DIV     = 5'd20,
    parameter logic [4:0]  ALU_DIVU    = 5'd21,
    parameter logic [4:0]  ALU_REM     = 5'd22,
    parameter logic [4:0]  ALU_REMU    = 5'd23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_dst,
    input  logic        ex_write_reg,
    input  logic [2:0]  ex_info_load,
    input  logic [4:0]  ex_alucode,
    input  logic        br_taken,
    input  logic        div_done,
    output logic        stall,
    output logic        flush_f,
    output logic        flush_d,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        DIVWAIT = 1'b1
    } state_t;

    // The count holds the number of completed DIVWAIT cycles, so the cycle in
    // which it equals DIV_TIMEOUT-1 is the DIV_TIMEOUT-th waiting cycle.
    localparam logic [5:0] WD_LAST = 6'(DIV_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  wd_cnt_q, wd_cnt_d;
    logic        div_busy_q;
    logic        div_err_q, div_err_d;
    logic [31:0] stall_cnt_q;

    logic is_div;
    logic ld_use;

    assign is_div = (ex_alucode == ALU_DIV)  || (ex_alucode == ALU_DIVU) ||
                    (ex_alucode == ALU_REM)  || (ex_alucode == ALU_REMU);

    // x0 is never a real producer, so ex_dst==0 can never create a hazard.
    assign ld_use = (ex_info_load != NOTLOAD) && ex_write_reg && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs1) || (ex_dst == id_rs2));

    always_comb begin
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        div_err_d = div_err_q;
        stall     = 1'b0;
        flush_f   = 1'b0;
        flush_d   = 1'b0;
        div_start = 1'b0;

        case (state_q)
            RUN: begin
                if (br_taken) begin
                    flush_f = 1'b1;
                    flush_d = 1'b1;
                end else if (is_div) begin
                    div_start = 1'b1;
                    stall     = 1'b1;
                    flush_d   = 1'b1;
                    state_d   = DIVWAIT;
                    wd_cnt_d  = 6'd0;
                end else if (ld_use) begin
                    // The bubble inserted into EX clears ld_use next cycle.
                    stall   = 1'b1;
                    flush_d = 1'b1;
                end
            end

            DIVWAIT: begin
                // EX holds only bubbles here, so br_taken/ld_use are ignored.
                if (div_done) begin
                    state_d = RUN;
                end else if (wd_cnt_q == WD_LAST) begin
                    div_err_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    stall    = 1'b1;
                    flush_d  = 1'b1;
                    wd_cnt_d = wd_cnt_q + 6'd1;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wd_cnt_q    <= 6'd0;
            div_busy_q  <= 1'b0;
            div_err_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wd_cnt_q   <= wd_cnt_d;
            div_busy_q <= (state_d == DIVWAIT);
            div_err_q  <= div_err_d;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign div_busy     = div_busy_q;
    assign div_err      = div_err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

    localparam int          TO_MAIN = 40;
    localparam int          TO_WD   = 8;
    localparam logic [2:0]  NOTLOAD = 3'd0;
    localparam logic [2:0]  LW      = 3'd1;
    localparam logic [4:0]  A_ADD   = 5'd0;
    localparam logic [4:0]  A_DIV   = 5'd20;
    localparam logic [4:0]  A_DIVU  = 5'd21;
    localparam logic [4:0]  A_REM   = 5'd22;
    localparam logic [4:0]  A_REMU  = 5'd23;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] dst;
        logic       wr;
        logic [2:0] ld;
        logic [4:0] alu;
        logic       br;
        logic       done;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [3:0] e;   // {stall, flush_f, flush_d, div_start}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_dst = '0, ex_alucode = '0;
    logic        ex_write_reg = 1'b0, br_taken = 1'b0, div_done = 1'b0;
    logic [2:0]  ex_info_load = '0;

    logic        stall, flush_f, flush_d, div_start, div_busy, div_err;
    logic [31:0] stall_cycles;
    logic        stall8, flush_f8, flush_d8, div_start8, div_busy8, div_err8;
    logic [31:0] stall_cycles8;

    int checks   = 0;
    int failures = 0;

    // Reference model state: in a divide or not, which waiting cycle we are in.
    bit      m_in_div;
    int      m_k;
    bit      m_err;
    longint  m_sc;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_TIMEOUT(TO_MAIN)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_dst(ex_dst),
        .ex_write_reg(ex_write_reg), .ex_info_load(ex_info_load), .ex_alucode(ex_alucode),
        .br_taken(br_taken), .div_done(div_done), .stall(stall), .flush_f(flush_f),
        .flush_d(flush_d), .div_start(div_start), .div_busy(div_busy), .div_err(div_err),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.DIV_TIMEOUT(TO_WD)) dut8 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_dst(ex_dst),
        .ex_write_reg(ex_write_reg), .ex_info_load(ex_info_load), .ex_alucode(ex_alucode),
        .br_taken(br_taken), .div_done(div_done), .stall(stall8), .flush_f(flush_f8),
        .flush_d(flush_d8), .div_start(div_start8), .div_busy(div_busy8), .div_err(div_err8),
        .stall_cycles(stall_cycles8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input int dst, input bit wr,
                               input logic [2:0] ld, input logic [4:0] alu,
                               input bit br, input bit done);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.dst = 5'(dst); v.wr = wr;
        v.ld = ld; v.alu = alu; v.br = br; v.done = done;
        return v;
    endfunction

    function automatic in_t nop();
        return mk(0, 0, 0, 0, NOTLOAD, A_ADD, 0, 0);
    endfunction

    task automatic drive(input in_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; ex_dst = v.dst; ex_write_reg = v.wr;
        ex_info_load = v.ld; ex_alucode = v.alu; br_taken = v.br; div_done = v.done;
    endtask

    task automatic model_reset();
        m_in_div = 0; m_k = 0; m_err = 0; m_sc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(nop());
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive at negedge, compare the main DUT against the
    // model 1ns later, then advance the model across the coming posedge.
    // Returns before the posedge so callers may add checks for this cycle.
    task automatic run_cycle(input in_t v);
        bit isdiv, ldu, rel;
        bit e_st, e_ff, e_fd, e_ds;
        @(negedge clk);
        drive(v);
        #1;
        isdiv = (v.alu == A_DIV) || (v.alu == A_DIVU) || (v.alu == A_REM) || (v.alu == A_REMU);
        ldu = (v.ld != NOTLOAD) && v.wr && (v.dst != 0) && ((v.dst == v.rs1) || (v.dst == v.rs2));
        e_st = 0; e_ff = 0; e_fd = 0; e_ds = 0; rel = 0;
        if (!m_in_div) begin
            if (v.br) begin
                e_ff = 1; e_fd = 1;
            end else if (isdiv) begin
                e_ds = 1; e_st = 1; e_fd = 1;
            end else if (ldu) begin
                e_st = 1; e_fd = 1;
            end
        end else begin
            rel  = v.done || (m_k == TO_MAIN);
            e_st = !rel;
            e_fd = !rel;
        end
        chk("stall", stall, e_st);
        chk("flush_f", flush_f, e_ff);
        chk("flush_d", flush_d, e_fd);
        chk("div_start", div_start, e_ds);
        chk("div_busy", div_busy, m_in_div);
        chk("div_err", div_err, m_err);
        chk("stall_cycles", stall_cycles, 32'(m_sc));
        if (e_st && m_sc != 64'hFFFF_FFFF) m_sc++;
        if (!m_in_div) begin
            if (e_ds) begin
                m_in_div = 1;
                m_k      = 1;
            end
        end else if (rel) begin
            if (!v.done) m_err = 1;
            m_in_div = 0;
        end else begin
            m_k++;
        end
    endtask

    vec_t tbl[11];

    initial begin
        int n_start, n_stall;
        in_t v;

        tbl[0]  = '{i: mk(1, 5, 5, 1, LW, A_ADD, 0, 0),       e: 4'b1010};
        tbl[1]  = '{i: nop(),                                 e: 4'b0000};
        tbl[2]  = '{i: mk(0, 0, 0, 1, LW, A_ADD, 0, 0),       e: 4'b0000};
        tbl[3]  = '{i: mk(6, 7, 5, 1, LW, A_ADD, 0, 0),       e: 4'b0000};
        tbl[4]  = '{i: mk(5, 0, 5, 0, LW, A_ADD, 0, 0),       e: 4'b0000};
        tbl[5]  = '{i: mk(0, 0, 0, 0, NOTLOAD, A_ADD, 1, 0),  e: 4'b0110};
        tbl[6]  = '{i: mk(0, 0, 0, 0, NOTLOAD, A_DIV, 1, 0),  e: 4'b0110};
        tbl[7]  = '{i: mk(5, 5, 5, 1, LW, A_ADD, 1, 0),       e: 4'b0110};
        tbl[8]  = '{i: mk(5, 0, 5, 1, NOTLOAD, A_ADD, 0, 0),  e: 4'b0000};
        tbl[9]  = '{i: mk(31, 2, 31, 1, 3'd4, A_ADD, 0, 0),   e: 4'b1010};
        tbl[10] = '{i: mk(0, 0, 0, 0, NOTLOAD, A_ADD, 0, 1),  e: 4'b0000};

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_busy", div_busy, 0);
        chk("reset_err", div_err, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        do_reset();

        // Single-cycle RUN vectors.
        for (int i = 0; i < 11; i++) begin
            run_cycle(tbl[i].i);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e[3]);
            chk($sformatf("tbl%0d_flush_f", i), flush_f, tbl[i].e[2]);
            chk($sformatf("tbl%0d_flush_d", i), flush_d, tbl[i].e[1]);
            chk($sformatf("tbl%0d_div_start", i), div_start, tbl[i].e[0]);
        end
        run_cycle(nop());
        chk("tbl_stall_cycles", stall_cycles, 2);

        // Divide with done at T+33.
        do_reset();
        n_start = 0; n_stall = 0;
        for (int k = 0; k <= 34; k++) begin
            if (k == 0)       v = mk(0, 0, 3, 1, NOTLOAD, A_DIV, 0, 0);
            else if (k == 33) v = mk(0, 0, 0, 0, NOTLOAD, A_ADD, 0, 1);
            else              v = nop();
            run_cycle(v);
            n_start += int'(div_start);
            n_stall += int'(stall);
            if (k >= 1 && k <= 33) chk("div_busy_window", div_busy, 1);
        end
        chk("div_start_pulses", n_start, 1);
        chk("div_stall_len", n_stall, 33);
        chk("div_busy_after", div_busy, 0);
        chk("div_stall_cycles", stall_cycles, 33);
        chk("div_err_none", div_err, 0);

        // Watchdog on the DIV_TIMEOUT=8 instance, then a normal divide.
        do_reset();
        run_cycle(mk(0, 0, 2, 1, NOTLOAD, A_REM, 0, 0));
        chk("wd_start", div_start8, 1);
        for (int k = 1; k <= 8; k++) begin
            run_cycle(nop());
            chk("wd_stall", stall8, (k < 8) ? 1 : 0);
            chk("wd_busy", div_busy8, 1);
            chk("wd_err_early", div_err8, 0);
        end
        run_cycle(nop());
        chk("wd_err_set", div_err8, 1);
        chk("wd_busy_clr", div_busy8, 0);
        chk("wd_stall_rel", stall8, 0);
        chk("wd_stall_cycles", stall_cycles8, 8);
        run_cycle(mk(0, 0, 2, 1, NOTLOAD, A_DIVU, 0, 0));
        chk("wd2_start", div_start8, 1);
        for (int k = 1; k <= 3; k++) begin
            run_cycle((k == 3) ? mk(0, 0, 0, 0, NOTLOAD, A_ADD, 0, 1) : nop());
            chk("wd2_stall", stall8, (k < 3) ? 1 : 0);
        end
        run_cycle(nop());
        chk("wd2_busy", div_busy8, 0);
        chk("wd2_err_sticky", div_err8, 1);

        // Done coinciding with the timeout cycle counts as done.
        do_reset();
        run_cycle(mk(0, 0, 2, 1, NOTLOAD, A_DIV, 0, 0));
        for (int k = 1; k <= 8; k++)
            run_cycle((k == 8) ? mk(0, 0, 0, 0, NOTLOAD, A_ADD, 0, 1) : nop());
        run_cycle(nop());
        chk("wd_edge_err", div_err8, 0);
        chk("wd_edge_busy", div_busy8, 0);

        // Asynchronous reset during DIVWAIT.
        do_reset();
        run_cycle(mk(0, 0, 4, 1, NOTLOAD, A_DIV, 0, 0));
        for (int k = 1; k <= 4; k++) run_cycle(nop());
        @(negedge clk);
        drive(nop());
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", div_busy, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_err", div_err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.dst  = 5'($urandom_range(0, 3));
            v.wr   = 1'($urandom_range(0, 1));
            v.ld   = ($urandom_range(0, 2) == 0) ? NOTLOAD : 3'($urandom_range(1, 5));
            v.alu  = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(20, 23))
                                                  : 5'($urandom_range(0, 19));
            v.br   = ($urandom_range(0, 4) == 0);
            v.done = ($urandom_range(0, 7) == 0);
            run_cycle(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the IF/ID/EX core. It sits beside `decoder` and drives the decoder's `flush` input, the front-end stall, and the start handshake of the iterative divider. It resolves three cases: load-use hazards, taken branches/jumps, and multi-cycle DIV/DIVU/REM/REMU occupancy. It also keeps a watchdog on the divider and a stall-cycle performance counter.

## Interface
- `DIV_TIMEOUT`, default 40: maximum DIVWAIT cycles before the watchdog fires; legal range 1..63.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1` in 5: rs1 field of the instruction in ID (`ir[19:15]`).
- `id_rs2` in 5: rs2 field of the instruction in ID (`ir[24:20]`).
- `ex_dst` in 5: `dstreg_num` from decoder (EX-stage instruction).
- `ex_write_reg` in 1: `write_reg` from decoder.
- `ex_info_load` in 3: `info_load` from decoder; `NOTLOAD` means not a load.
- `ex_alucode` in 5: `alucode` from decoder.
- `br_taken` in 1: EX-stage redirect (taken branch, JAL, JALR).
- `div_done` in 1: one-cycle pulse from the divider when its result is written back.
- `stall` out 1: hold PC and IR.
- `flush_f` out 1: replace the IR contents with a NOP at the next edge.
- `flush_d` out 1: connects to decoder `flush`; EX receives a bubble at the next edge.
- `div_start` out 1: one-cycle pulse; the divider latches operands, `ex_alucode` and `ex_dst` on this edge.
- `div_busy` out 1: high in DIVWAIT.
- `div_err` out 1: sticky watchdog flag.
- `stall_cycles` out 32: saturating count of cycles with `stall`=1.

## Operation
- Definitions:
  - `is_div` = `ex_alucode` ∈ {`DIV`, `DIVU`, `REM`, `REMU`}.
  - `ld_use` = (`ex_info_load` != `NOTLOAD`) & `ex_write_reg` & (`ex_dst` != 0) & (`ex_dst` == `id_rs1` | `ex_dst` == `id_rs2`).
- FSM has two states, RUN and DIVWAIT. Reset state is RUN.
- RUN, evaluated in this priority order:
  1. `br_taken`: `flush_f`=1, `flush_d`=1, `stall`=0. Stay in RUN.
  2. `is_div`: `div_start`=1, `stall`=1, `flush_d`=1. Go to DIVWAIT; clear the watchdog count to 0.
  3. `ld_use`: `stall`=1, `flush_d`=1 for exactly one cycle. The next cycle sees a bubble in EX, so `ld_use` self-clears.
  4. Otherwise all control outputs are 0.
- DIVWAIT:
  - While `div_done`=0: `stall`=1, `flush_d`=1, `div_busy`=1. The watchdog count increments each cycle.
  - `div_done`=1: `stall`=0, `flush_d`=0, `div_busy`=1 in this cycle. Go to RUN. The held ID instruction is re-decoded normally, so a dependency on the divide result sees the written-back value.
  - Count reaches `DIV_TIMEOUT` with no `div_done`: set `div_err`=1 (sticky until reset), release the stall as on `div_done`, and go to RUN.
  - `br_taken` and `ld_use` are ignored in DIVWAIT, because EX holds only bubbles.
- `stall`, `flush_f`, `flush_d` and `div_start` are combinational from state and inputs. `div_busy`, `div_err` and `stall_cycles` are registered.
- `stall_cycles` increments on every edge where `stall`=1 and holds at 32'hFFFF_FFFF.
- An rs=x0 comparison never causes a stall, because `ex_dst`=0 is excluded.

## Timing
- Reset values: state RUN, watchdog count 0, `div_busy`=0, `div_err`=0, `stall_cycles`=0. The combinational outputs are then 0 unless the RUN rules fire.
- Assertion of `rst` mid-DIVWAIT returns to RUN immediately. No `div_done` is awaited; the divider is reset by the same `rst`.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 killed slots (IR and EX).
- Divide: `div_start` is in cycle T and `div_busy` is high from T+1. If `div_done` arrives at T+N, `stall` is high in cycles T..T+N-1 and low at T+N.
- Watchdog: with no `div_done`, `div_err` rises at edge T+`DIV_TIMEOUT`+1.
- A `div_done` that coincides with the timeout cycle counts as done: `div_err` stays 0.
- A `div_done` received in RUN is ignored.

## Test plan
- Load-use: `lw x5` in EX (`ex_info_load`=LW, `ex_dst`=5, `ex_write_reg`=1) with `id_rs2`=5 → `stall`=1 and `flush_d`=1 for one cycle, then 0; `stall_cycles`=1.
- No false stall: the same load with `ex_dst`=0 and `id_rs1`=0, or with `id_rs1`=6 and `id_rs2`=7 → `stall`=0.
- Branch: `br_taken`=1 for one cycle → `flush_f`=1, `flush_d`=1, `stall`=0 in that cycle only; `stall_cycles` unchanged.
- Divide: `ex_alucode`=`DIV` at T, `div_done` at T+33 → one `div_start` pulse at T; `stall`=1 for 33 cycles; `div_busy` high T+1..T+33; `stall_cycles`=33; state RUN at T+34.
- Watchdog: `DIV_TIMEOUT`=8, no `div_done` → `div_err`=1 after edge T+9 and `stall` released; a second DIV then runs normally while `div_err` stays 1.
- Reset during DIVWAIT: assert `rst` at T+5 → asynchronously `div_busy`=0, `stall_cycles`=0, `div_err`=0, and `stall`=0.
